// File: rtl/event_log_arbiter.sv
// rtl/event_log_arbiter.sv - severity-aware round-robin arbiter feeding a timestamped event log FIFO
// ERROR requests pre-empt INFO; a finish sequence drains the log and latches a pass/fail verdict.
module event_log_arbiter #(
  parameter int N_SRC = 4,
  parameter int MSG_W = 16,
  parameter int TS_W  = 32,
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_SRC-1:0]           src_valid_i,
  input  logic [N_SRC-1:0]           src_sev_i,
  input  logic [N_SRC*MSG_W-1:0]     src_msg_i,
  output logic [N_SRC-1:0]           src_ready_o,
  output logic                       log_valid_o,
  input  logic                       log_ready_i,
  output logic [$clog2(N_SRC)-1:0]   log_src_o,
  output logic                       log_sev_o,
  output logic [MSG_W-1:0]           log_msg_o,
  output logic [TS_W-1:0]            log_ts_o,
  output logic [$clog2(DEPTH):0]     level_o,
  input  logic                       finish_i,
  input  logic                       clear_i,
  output logic                       error_seen_o,
  output logic [CNT_W-1:0]           error_cnt_o,
  output logic                       done_o,
  output logic                       pass_o
);

  localparam int SRC_W = $clog2(N_SRC);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_t;

  state_t                 state_q, state_d;
  logic [TS_W-1:0]        ts_q;
  logic [SRC_W-1:0]       rr_q;
  logic [SRC_W-1:0]       gnt_idx;
  logic                   gnt_found;
  logic [N_SRC-1:0]       elig;
  logic [N_SRC-1:0]       err_req;
  int                     idx;

  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [LVL_W-1:0]       count;
  logic                   push, pop, cap, push_sev, err_push;
  logic [MSG_W-1:0]       push_msg;
  logic                   err_seen_q;
  logic [CNT_W-1:0]       err_cnt_q;

  logic [SRC_W-1:0]       mem_src [DEPTH];
  logic                   mem_sev [DEPTH];
  logic [MSG_W-1:0]       mem_msg [DEPTH];
  logic [TS_W-1:0]        mem_ts  [DEPTH];

  // Any pending ERROR request masks out all INFO requests for this cycle.
  always_comb begin
    err_req   = src_valid_i & src_sev_i;
    elig      = (|err_req) ? err_req : src_valid_i;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int off = 0; off < N_SRC; off++) begin
      idx = int'(rr_q) + off;
      if (idx >= N_SRC) idx = idx - N_SRC;
      if (!gnt_found && elig[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = SRC_W'(idx);
      end
    end
  end

  assign log_valid_o = (count != '0);
  assign pop         = log_valid_o & log_ready_i;
  // A full log still takes a new entry when the head leaves in the same cycle.
  assign cap         = (count < LVL_W'(DEPTH)) | pop;

  always_comb begin
    src_ready_o = '0;
    if (state_q == ST_RUN && cap && gnt_found)
      src_ready_o = N_SRC'(1) << gnt_idx;
  end

  assign push     = |(src_valid_i & src_ready_o);
  assign push_sev = src_sev_i[gnt_idx];
  assign push_msg = src_msg_i[gnt_idx*MSG_W +: MSG_W];
  assign err_push = push & push_sev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q   <= '0;
      rr_q   <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      ts_q <= ts_q + TS_W'(1);
      if (push) begin
        rr_q   <= (gnt_idx == SRC_W'(N_SRC - 1)) ? '0 : gnt_idx + SRC_W'(1);
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + LVL_W'(1);
      else if (!push && pop) count <= count - LVL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_src[wr_ptr] <= gnt_idx;
      mem_sev[wr_ptr] <= push_sev;
      mem_msg[wr_ptr] <= push_msg;
      mem_ts[wr_ptr]  <= ts_q;
    end
  end

  // Head fields read as zero while the log is empty.
  assign log_src_o = log_valid_o ? mem_src[rd_ptr] : '0;
  assign log_sev_o = log_valid_o ? mem_sev[rd_ptr] : 1'b0;
  assign log_msg_o = log_valid_o ? mem_msg[rd_ptr] : '0;
  assign log_ts_o  = log_valid_o ? mem_ts[rd_ptr]  : '0;
  assign level_o   = count;

  // An ERROR accept in the clear cycle counts as the first event after the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_seen_q <= 1'b0;
      err_cnt_q  <= '0;
    end else if (clear_i) begin
      err_seen_q <= err_push;
      err_cnt_q  <= err_push ? CNT_W'(1) : '0;
    end else if (err_push) begin
      err_seen_q <= 1'b1;
      if (err_cnt_q != {CNT_W{1'b1}}) err_cnt_q <= err_cnt_q + CNT_W'(1);
    end
  end

  assign error_seen_o = err_seen_q;
  assign error_cnt_o  = err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (finish_i) state_d = ST_DRAIN;
      ST_DRAIN: if (count == '0) state_d = ST_DONE;
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_RUN;
    endcase
    if (clear_i) state_d = ST_RUN;
  end

  assign done_o = (state_q == ST_DONE);
  assign pass_o = (state_q == ST_DONE) & ~err_seen_q;

endmodule

// File: tb/tb_event_log_arbiter.sv
// tb/tb_event_log_arbiter.sv - directed self-checking bench for event_log_arbiter
module tb_event_log_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  src_valid_i;
  logic [3:0]  src_sev_i;
  logic [63:0] src_msg_i;
  logic [3:0]  src_ready_o;
  logic        log_valid_o;
  logic        log_ready_i;
  logic [1:0]  log_src_o;
  logic        log_sev_o;
  logic [15:0] log_msg_o;
  logic [31:0] log_ts_o;
  logic [4:0]  level_o;
  logic        finish_i;
  logic        clear_i;
  logic        error_seen_o;
  logic [15:0] error_cnt_o;
  logic        done_o;
  logic        pass_o;

  int checks = 0;
  int errors = 0;
  int exp_g;

  event_log_arbiter #(.N_SRC(4), .MSG_W(16), .TS_W(32), .DEPTH(16), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .src_valid_i(src_valid_i), .src_sev_i(src_sev_i), .src_msg_i(src_msg_i),
    .src_ready_o(src_ready_o),
    .log_valid_o(log_valid_o), .log_ready_i(log_ready_i),
    .log_src_o(log_src_o), .log_sev_o(log_sev_o), .log_msg_o(log_msg_o), .log_ts_o(log_ts_o),
    .level_o(level_o), .finish_i(finish_i), .clear_i(clear_i),
    .error_seen_o(error_seen_o), .error_cnt_o(error_cnt_o), .done_o(done_o), .pass_o(pass_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; src_valid_i = '0; src_sev_i = '0; src_msg_i = '0;
    log_ready_i = 1'b0; finish_i = 1'b0; clear_i = 1'b0;
    #12;
    check("rst_valid", 64'(log_valid_o), 64'd0);
    check("rst_level", 64'(level_o), 64'd0);
    check("rst_seen",  64'(error_seen_o), 64'd0);
    check("rst_cnt",   64'(error_cnt_o), 64'd0);
    check("rst_done",  64'(done_o), 64'd0);
    check("rst_pass",  64'(pass_o), 64'd0);
    check("rst_ready", 64'(src_ready_o), 64'd0);
    check("rst_ts",    64'(log_ts_o), 64'd0);
    rst_n = 1'b1;

    // 1: first accept after five cycles carries timestamp 5
    repeat (5) tick();
    src_valid_i = 4'b0001; src_msg_i[15:0] = 16'h1234;
    #1;
    check("t1_ready", 64'(src_ready_o), 64'h1);
    check("t1_pre_valid", 64'(log_valid_o), 64'd0);
    tick();
    src_valid_i = '0;
    check("t1_valid", 64'(log_valid_o), 64'd1);
    check("t1_ts",    64'(log_ts_o), 64'd5);
    check("t1_src",   64'(log_src_o), 64'd0);
    check("t1_sev",   64'(log_sev_o), 64'd0);
    check("t1_msg",   64'(log_msg_o), 64'h1234);
    check("t1_level", 64'(level_o), 64'd1);
    log_ready_i = 1'b1;
    tick();
    check("t1_drained", 64'(level_o), 64'd0);

    // 2: round robin among four INFO requesters; pointer sits at 1 after src0
    src_valid_i = 4'b1111; src_sev_i = '0;
    exp_g = 1;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("t2_grant", 64'(src_ready_o), 64'(4'b0001 << exp_g));
      check("t2_level_le1", 64'(level_o <= 5'd1), 64'd1);
      tick();
      exp_g = (exp_g + 1) % 4;
    end
    src_valid_i = '0;
    tick();
    check("t2_level_end", 64'(level_o), 64'd0);

    // 3: ERROR beats INFO
    src_valid_i = 4'b1010; src_sev_i = 4'b1000;
    #1;
    check("t3_err_first", 64'(src_ready_o), 64'b1000);
    tick();
    src_valid_i = 4'b0010; src_sev_i = '0;
    #1;
    check("t3_seen", 64'(error_seen_o), 64'd1);
    check("t3_cnt",  64'(error_cnt_o), 64'd1);
    check("t3_info_next", 64'(src_ready_o), 64'b0010);
    check("t3_head_src", 64'(log_src_o), 64'd3);
    check("t3_head_sev", 64'(log_sev_o), 64'd1);
    tick();
    src_valid_i = '0;
    check("t3_head2_src", 64'(log_src_o), 64'd1);
    check("t3_level", 64'(level_o), 64'd1);
    tick();
    check("t3_level_end", 64'(level_o), 64'd0);

    // 4: fill to DEPTH, then push alongside a pop
    log_ready_i = 1'b0; src_valid_i = 4'b0001; src_sev_i = '0;
    for (int i = 0; i < 16; i++) begin
      src_msg_i[15:0] = 16'h0100 + 16'(i);
      tick();
    end
    check("t4_full_level", 64'(level_o), 64'd16);
    check("t4_full_ready", 64'(src_ready_o), 64'd0);
    src_valid_i = 4'b0100; src_msg_i[47:32] = 16'hBEEF; log_ready_i = 1'b1;
    #1;
    check("t4_pushpop_ready", 64'(src_ready_o), 64'b0100);
    check("t4_head0", 64'(log_msg_o), 64'h0100);
    tick();
    src_valid_i = '0;
    check("t4_level_kept", 64'(level_o), 64'd16);
    for (int i = 1; i < 16; i++) begin
      check("t4_order", 64'(log_msg_o), 64'(16'h0100 + 16'(i)));
      tick();
    end
    check("t4_last_msg", 64'(log_msg_o), 64'hBEEF);
    check("t4_last_src", 64'(log_src_o), 64'd2);
    tick();
    check("t4_empty", 64'(level_o), 64'd0);

    // 5: finish sequence with one ERROR queued
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    check("t5_clr_cnt",  64'(error_cnt_o), 64'd0);
    check("t5_clr_seen", 64'(error_seen_o), 64'd0);
    log_ready_i = 1'b0;
    src_valid_i = 4'b0001; src_sev_i = 4'b0000; tick();
    src_valid_i = 4'b0010; src_sev_i = 4'b0010; tick();
    src_valid_i = 4'b0100; src_sev_i = 4'b0000; tick();
    src_valid_i = '0;
    check("t5_level3", 64'(level_o), 64'd3);
    check("t5_cnt1",   64'(error_cnt_o), 64'd1);
    finish_i = 1'b1;
    tick();
    finish_i = 1'b0; src_valid_i = 4'b0001;
    #1;
    check("t5_drain_ready", 64'(src_ready_o), 64'd0);
    check("t5_drain_done",  64'(done_o), 64'd0);
    log_ready_i = 1'b1;
    tick(); tick();
    check("t5_level1", 64'(level_o), 64'd1);
    tick();
    check("t5_level0", 64'(level_o), 64'd0);
    check("t5_not_done_yet", 64'(done_o), 64'd0);
    tick();
    check("t5_done", 64'(done_o), 64'd1);
    check("t5_pass", 64'(pass_o), 64'd0);
    check("t5_done_ready", 64'(src_ready_o), 64'd0);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    check("t5_run_done", 64'(done_o), 64'd0);
    check("t5_run_cnt",  64'(error_cnt_o), 64'd0);
    check("t5_run_ready", 64'(src_ready_o), 64'b0001);
    src_valid_i = '0;

    // clear coinciding with an ERROR accept leaves a count of one
    src_valid_i = 4'b0010; src_sev_i = 4'b0010;
    tick(); tick();
    check("tc_cnt2", 64'(error_cnt_o), 64'd2);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    check("tc_seen", 64'(error_seen_o), 64'd1);
    check("tc_cnt",  64'(error_cnt_o), 64'd1);

    // 6: saturation, then async reset mid-drain
    repeat (65540) tick();
    check("t6_sat", 64'(error_cnt_o), 64'hFFFF);
    log_ready_i = 1'b0;
    tick(); tick();
    src_valid_i = '0; finish_i = 1'b1;
    tick();
    finish_i = 1'b0; src_valid_i = 4'b0001; src_sev_i = '0;
    #1;
    check("t6_level3", 64'(level_o), 64'd3);
    check("t6_drain_ready", 64'(src_ready_o), 64'd0);
    check("t6_sat_hold", 64'(error_cnt_o), 64'hFFFF);
    #1 rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 64'(log_valid_o), 64'd0);
    check("t6_rst_level", 64'(level_o), 64'd0);
    check("t6_rst_cnt",   64'(error_cnt_o), 64'd0);
    check("t6_rst_seen",  64'(error_seen_o), 64'd0);
    #2 rst_n = 1'b1;
    tick();
    check("t6_run_ready", 64'(src_ready_o), 64'b0001);
    check("t6_run_done",  64'(done_o), 64'd0);
    src_valid_i = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/event_log_arbiter.md
Name: event_log_arbiter

Overview:
- Shares a single on-chip event log FIFO among N_SRC reporting blocks (filters, line buffers, stream checkers).
- Requesters post INFO or ERROR events; ERROR-class requests win over INFO-class requests, with round-robin arbitration inside each class.
- Each accepted event is stamped with a free-running cycle timestamp. A drain port (valid/ready) empties the log.
- A finish sequence drains the log and then reports a sticky pass/fail verdict.

Parameters:
- N_SRC, 4, number of requesters (≥2)
- MSG_W, 16, message payload width
- TS_W, 32, timestamp width
- DEPTH, 16, log FIFO depth (power of 2, ≥2)
- CNT_W, 16, width of the error counter

Ports:
- clk  in  1  sole clock
- rst_n  in  1  asynchronous active-low reset
- src_valid_i  in  N_SRC  per-source request
- src_sev_i  in  N_SRC  per-source severity (0=INFO, 1=ERROR)
- src_msg_i  in  N_SRC*MSG_W  per-source payload; source i occupies bits [i*MSG_W +: MSG_W]
- src_ready_o  out  N_SRC  one-hot grant, combinational
- log_valid_o  out  1  log head valid
- log_ready_i  in  1  drain accepts head
- log_src_o  out  $clog2(N_SRC)  source index of head entry
- log_sev_o  out  1  severity of head entry
- log_msg_o  out  MSG_W  payload of head entry
- log_ts_o  out  TS_W  timestamp of head entry
- level_o  out  $clog2(DEPTH)+1  FIFO occupancy
- finish_i  in  1  single-cycle pulse requesting the finish sequence
- clear_i  in  1  single-cycle pulse: return to RUN and clear status
- error_seen_o  out  1  sticky flag: an ERROR event has been accepted
- error_cnt_o  out  CNT_W  number of accepted ERROR events, saturating
- done_o  out  1  finish sequence complete
- pass_o  out  1  valid when done_o=1; equals !error_seen_o

Behaviour:
- Reset (async assert, sync deassert):
  - FIFO empty, timestamp = 0, RR pointer = 0, state RUN.
  - All outputs 0: log_valid_o, level_o, error_seen_o, error_cnt_o, done_o, pass_o, src_ready_o. log_* data = 0.
- Timestamp: increments by 1 every cycle after reset and wraps modulo 2^TS_W. It is never cleared by clear_i.
- Arbitration, combinational, in RUN only:
  - Capacity condition: level < DEPTH, or (log_valid_o & log_ready_i) this cycle.
  - If any valid source has sev=1, only ERROR sources are eligible; otherwise all valid sources are eligible.
  - Grant goes to the first eligible index at or after the RR pointer, with wrap.
  - src_ready_o[g]=1 for at most one g, and only when the capacity condition holds. src_ready_o may depend on src_valid_i.
- Accept (src_valid_i[g] & src_ready_o[g] at an edge):
  - Write {g, sev, msg, ts} to the FIFO. ts is the timestamp value during the accept cycle.
  - RR pointer ← (g+1) mod N_SRC. The pointer is unchanged when there is no accept.
- Latency: an entry accepted at edge k appears on log_* with log_valid_o=1 after edge k when the FIFO was empty. Output is first-word-fall-through from registers.
- Drain: head pops on log_valid_o & log_ready_i. log_* data holds stable while log_valid_o=1 and log_ready_i=0.
- Simultaneous push and pop: level unchanged. When full, the push is allowed only with a same-cycle pop.
- Status counters:
  - error_seen_o sets on accept of an ERROR entry (not on drain).
  - error_cnt_o increments on ERROR accept and saturates at 2^CNT_W−1.
  - clear_i zeroes both. If an ERROR accept coincides with clear_i, the result is error_seen_o=1 and error_cnt_o=1.
- FSM:
  - RUN: normal operation. finish_i → DRAIN.
  - DRAIN: src_ready_o=0; drain continues. When level=0 (checked each cycle, including on entry) → DONE.
  - DONE: done_o=1, pass_o=!error_seen_o; src_ready_o=0. clear_i → RUN.
  - clear_i in RUN or DRAIN → RUN, clears status, and leaves FIFO contents intact.
  - finish_i outside RUN is ignored. clear_i has priority over finish_i in the same cycle.
- Reset mid-operation: all state is lost immediately, including FIFO entries and the FSM state.

Test Plan:
1. Reset → all outputs 0. After 5 cycles out of reset, src0 pushes msg=0x1234 INFO → log_ts_o=5, log_src_o=0, log_sev_o=0, and log_valid_o=1 one cycle after the accept.
2. All 4 sources hold INFO valid continuously, log_ready_i=1 → grants cycle 0,1,2,3,0,… with exactly one src_ready_o bit per cycle; level_o stays ≤1.
3. src1 INFO and src3 ERROR valid together → src3 is granted first, error_seen_o=1 and error_cnt_o=1 the next cycle, and src1 is granted the following cycle.
4. log_ready_i=0 with 16 INFO pushes → level_o=16 and src_ready_o=0. Then assert log_ready_i with src2 valid → pop and push occur in the same cycle, level_o stays 16, and head data is FIFO-ordered.
5. 3 entries queued, one of them ERROR, pulse finish_i → src_ready_o=0 during drain; done_o rises the cycle after the last pop with pass_o=0. Pulse clear_i → state RUN, done_o=0, error_cnt_o=0.
6. Force error_cnt_o to 0xFFFF via ERROR pushes → remains at 0xFFFF. Then assert rst_n=0 mid-drain → log_valid_o, level_o and error_cnt_o go to 0 asynchronously.
